// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and instruction-memory write bus of the program loader
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader writing instruction memory; holds the core until a good image lands
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int         ADDR_W    = 8,
`ifdef PROG_LOADER_TIMEOUT_EN
  parameter int         TIMEOUT_CYC = 1024,
`endif
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         CLB,
  prog_loader_if.slave bus,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [31:0] MEM_DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_hold_q, core_hold_d;
  logic              in_ready;
  logic              accept;
  logic [8:0]        len_plus1;
  logic [CNT_W-1:0]  idx_inc;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // DONE is the only state that refuses bytes; the image is frozen until reset
  assign in_ready = (state_q != S_DONE);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    len_plus1   = {1'b0, bus.in_data} + 9'd1;
    idx_inc     = idx_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept && bus.in_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (32'(len_plus1) > MEM_DEPTH) begin
            state_d = S_ERROR;
          end else begin
            count_d = CNT_W'(len_plus1);
            idx_d   = '0;
            sum_d   = 8'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          sum_d       = sum_q + bus.in_data;
          idx_d       = idx_inc;
          if (idx_inc == count_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_d = (8'(sum_q + bus.in_data) == 8'd0) ? S_DONE : S_ERROR;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

`ifdef PROG_LOADER_TIMEOUT_EN
    // counter measures idle cycles since the last accepted byte of an open frame
    tmo_d = '0;
    if (!accept && (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM)) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC)) state_d = S_ERROR;
      else                              tmo_d   = tmo_q + TMO_W'(1);
    end
`endif

    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
    core_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q     <= S_IDLE;
      sum_q       <= 8'd0;
      count_q     <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_hold_q <= 1'b1;
`ifdef PROG_LOADER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_hold_q <= core_hold_d;
`ifdef PROG_LOADER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign core_hold     = core_hold_q;

endmodule
